// File: rtl/rep3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : rep3_serial_tx
// Description : Transmit end of the triple-repetition serial link. Takes a
//               parallel word over a valid/ready handshake and sends it LSB
//               first, each data bit as three identical line symbols, framed
//               by one low start symbol and one high stop symbol. The line
//               idles high. Each symbol is held for CLKS_PER_SYM cycles.
// Ports       : clk        - system clock, rising-edge active
//               rst        - synchronous active-high reset
//               in_data    - word to transmit, sampled only on accept
//               in_valid   - in_data is valid
//               in_ready   - high only while idle (word can be accepted)
//               tx_line    - registered serial line output, idle high
//               tx_busy    - registered, high during START, DATA and STOP
//               frame_done - registered one-cycle pulse after the stop symbol
// Revision    : 1.0 - initial release
// ============================================================================
module rep3_serial_tx #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_SYM = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tx_line,
  output logic             tx_busy,
  output logic             frame_done
);

  // Counter widths are kept at least one bit so WIDTH=1 / CLKS_PER_SYM=1 work.
  localparam int c_BW = (WIDTH > 1)        ? $clog2(WIDTH)        : 1;
  localparam int c_CW = (CLKS_PER_SYM > 1) ? $clog2(CLKS_PER_SYM) : 1;

  localparam logic [c_BW-1:0] c_LAST_BIT = c_BW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_LAST_CLK = c_CW'(CLKS_PER_SYM - 1);
  localparam logic [1:0]      c_LAST_REP = 2'd2;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_START = 2'd1;
  localparam logic [1:0] c_DATA  = 2'd2;
  localparam logic [1:0] c_STOP  = 2'd3;

  logic [1:0]       r_state;
  logic [c_CW-1:0]  r_clk_cnt;
  logic [1:0]       r_rep_cnt;
  logic [c_BW-1:0]  r_bit_idx;
  logic [WIDTH-1:0] r_shift;

  logic             w_sym_end;
  logic [WIDTH-1:0] w_shift_next;

  assign in_ready     = (r_state == c_IDLE);
  assign w_sym_end    = (r_clk_cnt == c_LAST_CLK);
  assign w_shift_next = r_shift >> 1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= c_IDLE;
      r_clk_cnt  <= '0;
      r_rep_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      tx_line    <= 1'b1;
      tx_busy    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (in_valid) begin
            r_shift   <= in_data;
            r_state   <= c_START;
            r_clk_cnt <= '0;
            tx_line   <= 1'b0;
            tx_busy   <= 1'b1;
          end
        end

        c_START: begin
          if (w_sym_end) begin
            r_clk_cnt <= '0;
            r_state   <= c_DATA;
            r_rep_cnt <= '0;
            r_bit_idx <= '0;
            tx_line   <= r_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        c_DATA: begin
          if (w_sym_end) begin
            r_clk_cnt <= '0;
            if (r_rep_cnt == c_LAST_REP) begin
              // Third copy of this bit done: move on to the next bit or stop.
              r_shift   <= w_shift_next;
              r_rep_cnt <= '0;
              if (r_bit_idx == c_LAST_BIT) begin
                r_state <= c_STOP;
                tx_line <= 1'b1;
              end else begin
                r_bit_idx <= r_bit_idx + 1'b1;
                // Line must show the next bit in the same cycle the shift
                // register advances, so drive it from the shifted value.
                tx_line   <= w_shift_next[0];
              end
            end else begin
              r_rep_cnt <= r_rep_cnt + 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        c_STOP: begin
          if (w_sym_end) begin
            r_clk_cnt  <= '0;
            r_state    <= c_IDLE;
            tx_line    <= 1'b1;
            tx_busy    <= 1'b0;
            frame_done <= 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end

        default: begin
          r_state <= c_IDLE;
          tx_line <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rep3_serial_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_rep3_serial_tx
// Description : Self-checking bench for rep3_serial_tx. Three instances with
//               different WIDTH / CLKS_PER_SYM share clock and reset. Accepted
//               words go into per-instance queues; a monitor captures each
//               frame off the line and compares it with a waveform built
//               from the framing rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rep3_serial_tx;

  typedef bit bitq_t[$];

  localparam int c_N = 3;
  int c_W[c_N] = '{8, 8, 1};
  int c_C[c_N] = '{4, 1, 2};

  logic       clk;
  logic       rst;
  logic [2:0] valid;
  logic [7:0] din [c_N];
  logic [2:0] ready, line, busy, done;

  int total = 0;
  int bad   = 0;

  logic [7:0] expq [c_N][$];
  bit         capq [c_N][$];
  bit         rst_pend = 1'b0;

  rep3_serial_tx #(.WIDTH(8), .CLKS_PER_SYM(4)) u_dut0 (
    .clk(clk), .rst(rst), .in_data(din[0]), .in_valid(valid[0]),
    .in_ready(ready[0]), .tx_line(line[0]), .tx_busy(busy[0]), .frame_done(done[0]));

  rep3_serial_tx #(.WIDTH(8), .CLKS_PER_SYM(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_data(din[1]), .in_valid(valid[1]),
    .in_ready(ready[1]), .tx_line(line[1]), .tx_busy(busy[1]), .frame_done(done[1]));

  rep3_serial_tx #(.WIDTH(1), .CLKS_PER_SYM(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(din[2][0:0]), .in_valid(valid[2]),
    .in_ready(ready[2]), .tx_line(line[2]), .tx_busy(busy[2]), .frame_done(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: start(0), each bit three times LSB first, stop(1), each symbol
  // stretched to cps cycles.
  function automatic bitq_t ref_wave(input logic [7:0] w, input int width, input int cps);
    bitq_t syms;
    bitq_t wave;
    syms.push_back(1'b0);
    for (int b = 0; b < width; b++)
      for (int r = 0; r < 3; r++) syms.push_back(w[b]);
    syms.push_back(1'b1);
    foreach (syms[s])
      for (int c = 0; c < cps; c++) wave.push_back(syms[s]);
    return wave;
  endfunction

  // Monitor / scoreboard; also records accepts (seen one half-cycle early).
  always @(negedge clk) begin
    for (int i = 0; i < c_N; i++) begin
      if (rst_pend) begin
        total++;
        if (line[i] !== 1'b1 || busy[i] !== 1'b0 || done[i] !== 1'b0) begin
          bad++;
          $display("FAIL reset_out inst=%0d got line=%b busy=%b done=%b want 1 0 0",
                   i, line[i], busy[i], done[i]);
        end
        capq[i].delete();
        expq[i].delete();
      end else begin
        if (busy[i] === 1'b1) capq[i].push_back(line[i]);
        if (done[i] === 1'b1) begin
          total++;
          if (expq[i].size() == 0) begin
            bad++;
            $display("FAIL spurious_done inst=%0d got frame_done=1 want no frame pending", i);
          end else begin
            logic [7:0] w;
            bitq_t exp;
            int mis;
            w   = expq[i].pop_front();
            exp = ref_wave(w, c_W[i], c_C[i]);
            mis = -1;
            for (int k = 0; k < exp.size(); k++)
              if (mis < 0 && (k >= capq[i].size() || capq[i][k] != exp[k])) mis = k;
            if (capq[i].size() != exp.size() || mis >= 0) begin
              bad++;
              $display("FAIL frame inst=%0d word=%h got len=%0d want len=%0d first_diff=%0d",
                       i, w, capq[i].size(), exp.size(), mis);
            end
          end
          total++;
          if (ready[i] !== 1'b1 || line[i] !== 1'b1 || busy[i] !== 1'b0) begin
            bad++;
            $display("FAIL done_cycle inst=%0d got ready=%b line=%b busy=%b want 1 1 0",
                     i, ready[i], line[i], busy[i]);
          end
          capq[i].delete();
        end
      end
      if (!rst && valid[i] && ready[i]) expq[i].push_back(din[i]);
    end
    rst_pend = rst;
  end

  task automatic wait_done(input int i);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done[i]) return;
    end
    total++; bad++;
    $display("FAIL done_timeout inst=%0d got no frame_done want one within 3000 cycles", i);
  endtask

  task automatic send(input int i, input logic [7:0] w, input bit wait_end);
    bit ok;
    ok = 1'b0;
    @(posedge clk); #1;
    din[i]   = w;
    valid[i] = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (ready[i]) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      total++; bad++;
      $display("FAIL accept_timeout inst=%0d got in_ready=0 want 1", i);
    end
    @(posedge clk); #1;
    valid[i] = 1'b0;
    if (wait_end) wait_done(i);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog got simulation still running want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst   = 1'b1;
    valid = 3'b111;
    for (int i = 0; i < c_N; i++) din[i] = 8'hFF;

    // Reset held with in_valid high; monitor checks outputs each cycle.
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    valid = 3'b000;
    @(negedge clk);
    total++;
    if (ready !== 3'b111) begin
      bad++;
      $display("FAIL ready_after_reset got %b want 111", ready);
    end

    // Single frame 0xA5.
    send(0, 8'hA5, 1'b1);

    // Hold-off: in_valid stays high, data changes mid-frame.
    @(posedge clk); #1;
    din[0] = 8'h3C; valid[0] = 1'b1;
    repeat (30) @(posedge clk);
    #1 din[0] = 8'hFF;
    wait_done(0);
    @(posedge clk); #1 valid[0] = 1'b0;
    @(negedge clk);
    total++;
    if (busy[0] !== 1'b1 || line[0] !== 1'b0) begin
      bad++;
      $display("FAIL b2b_start got busy=%b line=%b want busy=1 line=0", busy[0], line[0]);
    end
    wait_done(0);

    // One-cycle symbols.
    send(1, 8'h01, 1'b1);

    // Reset mid-frame during bit 3 repetition 2 of 0xA5.
    send(0, 8'hA5, 1'b0);
    repeat (45) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    seen = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (done[0]) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL abort_no_done got frame_done=1 want 0 after mid-frame reset");
    end
    send(0, 8'h5A, 1'b1);

    // WIDTH=1 frames.
    send(2, 8'h01, 1'b1);
    send(2, 8'h00, 1'b1);

    // Random traffic on all instances concurrently.
    fork
      for (int n = 0; n < 5; n++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        send(0, 8'($urandom), 1'b1);
      end
      for (int n = 0; n < 12; n++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        send(1, 8'($urandom), 1'b1);
      end
      for (int n = 0; n < 12; n++) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        send(2, 8'($urandom_range(0, 1)), 1'b1);
      end
    join

    repeat (5) @(negedge clk);
    for (int i = 0; i < c_N; i++) begin
      total++;
      if (expq[i].size() != 0) begin
        bad++;
        $display("FAIL leftover inst=%0d got %0d pending frames want 0", i, expq[i].size());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rep3_serial_tx.md
Name: rep3_serial_tx

Overview:
- Transmit end of our triple-repetition serial link; the majority-vote receiver is the other end.
- Accepts a parallel word through a valid/ready handshake.
- Serializes the word LSB first and sends each data bit as three identical consecutive symbols, so the receiver can majority-vote (2 of 3) each bit.
- Framed with one start symbol and one stop symbol; the line idles high.

Parameters:
WIDTH, 8, data word width in bits (>=1)
CLKS_PER_SYM, 4, clock cycles each line symbol is held (>=1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_data  input  WIDTH  word to transmit; sampled only on accept
in_valid  input  1  in_data is valid
in_ready  output  1  block can accept a word (high only in IDLE)
tx_line  output  1  serial line output, idle high
tx_busy  output  1  high while a frame is on the line (START, DATA, STOP)
frame_done  output  1  one-cycle pulse after the stop symbol completes

Behaviour:
- Reset (rst=1 at a rising edge) forces the following on the next cycle, overriding every other input:
  - state=IDLE, tx_line=1, tx_busy=0, frame_done=0.
  - All counters and the shift register cleared.
  - in_ready=1 after reset, because in_ready = (state==IDLE).
- Registered outputs: tx_line, tx_busy, frame_done. in_ready is decoded from state.
- Accept: in_valid & in_ready at a rising edge.
  - in_data is latched into the shift register.
  - State goes to START; tx_line=0 and tx_busy=1 from the next cycle.
  - in_data and in_valid are ignored whenever in_ready=0.
- Symbol timing: clk_cnt counts 0..CLKS_PER_SYM-1. Each symbol holds tx_line for exactly CLKS_PER_SYM cycles.
- States:
  - IDLE: tx_line=1. Goes to START on accept.
  - START: tx_line=0 for one symbol, then DATA with bit_idx=0 and rep_cnt=0.
  - DATA: tx_line = shift_reg[0].
    - rep_cnt counts 0..2, advancing once per symbol.
    - When rep_cnt=2 and the symbol ends: shift right by 1, rep_cnt=0, bit_idx+1.
    - When bit_idx=WIDTH-1 and rep_cnt=2 and the symbol ends: go to STOP.
  - STOP: tx_line=1 for one symbol.
    - Then go to IDLE; tx_busy=0 and frame_done=1 for exactly one cycle, both in the first IDLE cycle.
- Frame length is (2 + 3*WIDTH)*CLKS_PER_SYM cycles, counted from the cycle after accept.
- Back-to-back frames:
  - The earliest next accept is at the edge ending the first IDLE cycle, i.e. the cycle frame_done is high.
  - This gives a minimum gap of one idle-high cycle between frames. No accept is allowed during STOP.
- CLKS_PER_SYM=1: every symbol is a single cycle, with no stretching or skipped cycles.
- The latched word is immune to in_data changes after accept.
- Reset mid-frame aborts immediately:
  - tx_line=1 next cycle, no frame_done pulse.
  - The partial frame is not resumed.
- No other error conditions exist. in_valid may stay asserted continuously; one word is taken per IDLE visit.

Test Plan:
- Reset:
  - Stimulus: hold rst for 3 cycles with in_valid=1.
  - Required: tx_line=1, tx_busy=0, frame_done=0 throughout. in_ready=1 on the first cycle after rst drops. No frame starts while rst=1.
- Single frame, WIDTH=8, CLKS_PER_SYM=4:
  - Stimulus: accept in_data=0xA5.
  - Required symbol sequence (4 cycles each): 0 | 111 000 111 000 000 111 000 111 | 1.
  - Required timing: tx_busy high for 104 cycles. frame_done=1 and in_ready=1 on cycle 105 after the accept edge.
- Handshake hold-off:
  - Stimulus: in_valid held high with in_data=0x3C, then change in_data to 0xFF mid-frame.
  - Required:
    - The frame carries 0x3C (LSB first: 000 000 111 111 111 111 000 000).
    - 0xFF is accepted at the edge ending cycle 105 (the frame_done cycle); its start bit appears on cycle 106.
    - Exactly one idle-high cycle lies between the two frames.
- CLKS_PER_SYM=1, WIDTH=8:
  - Stimulus: accept 0x01.
  - Required: tx_line = 0,1,1,1, then 21 zeros, then 1. Total 26 cycles. frame_done on cycle 27.
- Reset mid-frame:
  - Stimulus: assert rst during the 2nd repetition of bit 3 of 0xA5.
  - Required: tx_line=1, tx_busy=0 next cycle, and no frame_done pulse. A new accept of 0x5A afterwards produces a complete, correct frame.
- WIDTH=1, CLKS_PER_SYM=2:
  - Stimulus: accept 1, then after completion accept 0.
  - Required: frames are 0,0 | 1×6 | 1,1 (10 cycles) and 0,0 | 0×6 | 1,1.
